// File: rtl/axis_pkt_stats_pkg.sv
// Shared definitions for the AXI-Stream TX statistics tap.
//   - keep_w_of / ch_w_of : derive tkeep width and read-select width from the
//                           top-level parameters.
//   - popcount            : number of set bits in a tkeep beat (zero-extended
//                           to MAX_KEEP_W by the caller).
//   - sat_add             : add an increment to a W-bit counter held in an
//                           ACC_W-bit container, either saturating at all-ones
//                           or wrapping, and flag the overflow.
package axis_pkt_stats_pkg;

    localparam int MAX_KEEP_W = 256;
    localparam int ACC_W      = 64;

    typedef struct packed {
        logic             ovf;
        logic [ACC_W-1:0] val;
    } acc_res_t;

    function automatic int keep_w_of(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int ch_w_of(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic logic [8:0] popcount(input logic [MAX_KEEP_W-1:0] v);
        logic [8:0] n;
        n = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            n = n + 9'(v[i]);
        end
        return n;
    endfunction

    // a and inc are both below 2^w, so the extra top bit of the sum is enough
    // to detect any overflow of the w-bit counter.
    function automatic acc_res_t sat_add(input logic [ACC_W-1:0] a,
                                         input logic [ACC_W-1:0] inc,
                                         input int               w,
                                         input logic             sat);
        logic [ACC_W:0] sum;
        logic [ACC_W:0] lim;
        acc_res_t       res;
        sum     = {1'b0, a} + {1'b0, inc};
        lim     = {(ACC_W+1){1'b1}} >> (ACC_W + 1 - w);
        res.ovf = (sum > lim);
        if (res.ovf) begin
            sum = sat ? lim : (sum & lim);
        end
        res.val = sum[ACC_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/axis_ch_stat.sv
// One monitored channel of the statistics tap.
// Tracks start-of-packet, live packet/byte counters and a sticky overflow
// flag, and holds the shadow copy loaded by a snapshot.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_tvalid/i_tready     stream handshake (observed only)
//   i_tlast, i_tkeep      beat qualifiers
//   i_snap_req            capture live values into the shadow this cycle
//   i_snap_clr            with i_snap_req: restart live counters and ovf
//   o_sh_pkt/byte/ovf     shadow registers
//
// Handshake: a beat is transferred in any cycle where tvalid and tready are
// both high; this block never drives the stream, it only counts such beats.
module axis_ch_stat
    import axis_pkt_stats_pkg::*;
#(
    parameter int KEEP_W   = 32,
    parameter int PKT_W    = 32,
    parameter int BYTE_W   = 48,
    parameter int SAT_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tvalid,
    input  logic              i_tready,
    input  logic              i_tlast,
    input  logic [KEEP_W-1:0] i_tkeep,
    input  logic              i_snap_req,
    input  logic              i_snap_clr,
    output logic [PKT_W-1:0]  o_sh_pkt,
    output logic [BYTE_W-1:0] o_sh_byte,
    output logic              o_sh_ovf
);

    logic              r_sop;
    logic [PKT_W-1:0]  r_pkt;
    logic [BYTE_W-1:0] r_byte;
    logic              r_ovf;
    logic [PKT_W-1:0]  r_sh_pkt;
    logic [BYTE_W-1:0] r_sh_byte;
    logic              r_sh_ovf;

    logic              w_beat;
    logic              w_clr;
    logic [PKT_W-1:0]  w_pkt_base;
    logic [BYTE_W-1:0] w_byte_base;
    logic              w_ovf_base;
    logic [ACC_W-1:0]  w_pkt_inc;
    logic [ACC_W-1:0]  w_byte_inc;
    acc_res_t          w_pkt_res;
    acc_res_t          w_byte_res;
    logic              w_unused_hi;

    assign w_beat = i_tvalid & i_tready;
    assign w_clr  = i_snap_req & i_snap_clr;

    // A clearing snapshot restarts from zero but still adds this cycle's
    // beat, so traffic coincident with the snapshot is never dropped.
    assign w_pkt_base  = w_clr ? '0   : r_pkt;
    assign w_byte_base = w_clr ? '0   : r_byte;
    assign w_ovf_base  = w_clr ? 1'b0 : r_ovf;

    assign w_pkt_inc  = ACC_W'(w_beat & r_sop);
    assign w_byte_inc = w_beat ? ACC_W'(popcount(MAX_KEEP_W'(i_tkeep))) : '0;

    assign w_pkt_res  = sat_add(ACC_W'(w_pkt_base), w_pkt_inc, PKT_W, SAT_MODE != 0);
    assign w_byte_res = sat_add(ACC_W'(w_byte_base), w_byte_inc, BYTE_W, SAT_MODE != 0);

    // Bits above the counter width are always zero after sat_add.
    assign w_unused_hi = ^{w_pkt_res.val >> PKT_W, w_byte_res.val >> BYTE_W};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sop     <= 1'b1;
            r_pkt     <= '0;
            r_byte    <= '0;
            r_ovf     <= 1'b0;
            r_sh_pkt  <= '0;
            r_sh_byte <= '0;
            r_sh_ovf  <= 1'b0;
        end else begin
            if (w_beat) begin
                r_sop <= i_tlast;
            end
            r_pkt  <= w_pkt_res.val[PKT_W-1:0];
            r_byte <= w_byte_res.val[BYTE_W-1:0];
            r_ovf  <= w_ovf_base | w_pkt_res.ovf | w_byte_res.ovf;
            // Shadows take the pre-increment live values.
            if (i_snap_req) begin
                r_sh_pkt  <= r_pkt;
                r_sh_byte <= r_byte;
                r_sh_ovf  <= r_ovf;
            end
        end
    end

    assign o_sh_pkt  = r_sh_pkt;
    assign o_sh_byte = r_sh_byte;
    assign o_sh_ovf  = r_sh_ovf;

endmodule

// File: rtl/axis_pkt_stats.sv
// Passive multi-channel AXI-Stream TX statistics tap.
// Per channel: packet count, payload byte count (tkeep popcount) and sticky
// overflow; an atomic snapshot copies all channels into shadows which are
// read back by channel index.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_tvalid/tready   per-channel handshake (observed only)
//   s_tlast, s_tkeep  per-channel beat qualifiers, tkeep ch i at [i*KEEP_W +: KEEP_W]
//   snap_req/clr      snapshot all channels / also restart live counters
//   rd_ch             shadow read select (out-of-range reads return zero)
//   rd_*              registered shadow of rd_ch
//   snap_done         pulses the cycle after snap_req
module axis_pkt_stats
    import axis_pkt_stats_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    parameter  int DATA_W   = 256,
    parameter  int PKT_W    = 32,
    parameter  int BYTE_W   = 48,
    parameter  int SAT_MODE = 1,
    localparam int KEEP_W   = keep_w_of(DATA_W),
    localparam int CH_W     = ch_w_of(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        s_tvalid,
    input  logic [NUM_CH-1:0]        s_tready,
    input  logic [NUM_CH-1:0]        s_tlast,
    input  logic [NUM_CH*KEEP_W-1:0] s_tkeep,
    input  logic                     snap_req,
    input  logic                     snap_clr,
    input  logic [CH_W-1:0]          rd_ch,
    output logic [PKT_W-1:0]         rd_pkt_count,
    output logic [BYTE_W-1:0]        rd_byte_count,
    output logic                     rd_ovf,
    output logic                     snap_done
);

    logic [PKT_W-1:0]  w_sh_pkt  [NUM_CH];
    logic [BYTE_W-1:0] w_sh_byte [NUM_CH];
    logic              w_sh_ovf  [NUM_CH];

    logic [31:0]       w_rd_idx;
    logic [PKT_W-1:0]  w_rd_pkt;
    logic [BYTE_W-1:0] w_rd_byte;
    logic              w_rd_ovf;

    logic [PKT_W-1:0]  r_rd_pkt;
    logic [BYTE_W-1:0] r_rd_byte;
    logic              r_rd_ovf;
    logic              r_snap_done;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        axis_ch_stat #(
            .KEEP_W  (KEEP_W),
            .PKT_W   (PKT_W),
            .BYTE_W  (BYTE_W),
            .SAT_MODE(SAT_MODE)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_tvalid  (s_tvalid[g]),
            .i_tready  (s_tready[g]),
            .i_tlast   (s_tlast[g]),
            .i_tkeep   (s_tkeep[g*KEEP_W +: KEEP_W]),
            .i_snap_req(snap_req),
            .i_snap_clr(snap_clr),
            .o_sh_pkt  (w_sh_pkt[g]),
            .o_sh_byte (w_sh_byte[g]),
            .o_sh_ovf  (w_sh_ovf[g])
        );
    end

    // Compare on a 32-bit index so channel numbers past NUM_CH simply match
    // nothing and fall through to the zero defaults.
    assign w_rd_idx = 32'(rd_ch);

    always_comb begin
        w_rd_pkt  = '0;
        w_rd_byte = '0;
        w_rd_ovf  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_rd_idx == 32'(i)) begin
                w_rd_pkt  = w_sh_pkt[i];
                w_rd_byte = w_sh_byte[i];
                w_rd_ovf  = w_sh_ovf[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pkt    <= '0;
            r_rd_byte   <= '0;
            r_rd_ovf    <= 1'b0;
            r_snap_done <= 1'b0;
        end else begin
            r_rd_pkt    <= w_rd_pkt;
            r_rd_byte   <= w_rd_byte;
            r_rd_ovf    <= w_rd_ovf;
            r_snap_done <= snap_req;
        end
    end

    assign rd_pkt_count  = r_rd_pkt;
    assign rd_byte_count = r_rd_byte;
    assign rd_ovf        = r_rd_ovf;
    assign snap_done     = r_snap_done;

endmodule

// File: tb/tb_axis_pkt_stats.sv
// Directed bench for axis_pkt_stats.
// u_dut  : NUM_CH=4, DATA_W=256, default counter widths, saturating.
// u_sat  : NUM_CH=3, DATA_W=32, PKT_W=4, BYTE_W=8, saturating.
// u_wrap : same as u_sat but wrapping. NUM_CH=3 leaves rd_ch=3 out of range.
// Inputs are driven just after the falling edge, outputs sampled on it.
module tb_axis_pkt_stats;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   s_tvalid, s_tready, s_tlast;
    logic [127:0] s_tkeep;
    logic         snap_req, snap_clr;
    logic [1:0]   rd_ch;
    logic [31:0]  rd_pkt_count;
    logic [47:0]  rd_byte_count;
    logic         rd_ovf, snap_done;

    logic [2:0]   t_tvalid, t_tready, t_tlast;
    logic [11:0]  t_tkeep;
    logic         t_snap_req, t_snap_clr;
    logic [1:0]   t_rd_ch;
    logic [3:0]   sat_pkt, wrap_pkt;
    logic [7:0]   sat_byte, wrap_byte;
    logic         sat_ovf, wrap_ovf, sat_done, wrap_done;

    int n_checks = 0;
    int n_errors = 0;

    axis_pkt_stats #(.NUM_CH(4), .DATA_W(256), .PKT_W(32), .BYTE_W(48), .SAT_MODE(1)) u_dut (
        .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_tkeep(s_tkeep), .snap_req(snap_req), .snap_clr(snap_clr), .rd_ch(rd_ch),
        .rd_pkt_count(rd_pkt_count), .rd_byte_count(rd_byte_count), .rd_ovf(rd_ovf),
        .snap_done(snap_done)
    );

    axis_pkt_stats #(.NUM_CH(3), .DATA_W(32), .PKT_W(4), .BYTE_W(8), .SAT_MODE(1)) u_sat (
        .clk(clk), .rst(rst), .s_tvalid(t_tvalid), .s_tready(t_tready), .s_tlast(t_tlast),
        .s_tkeep(t_tkeep), .snap_req(t_snap_req), .snap_clr(t_snap_clr), .rd_ch(t_rd_ch),
        .rd_pkt_count(sat_pkt), .rd_byte_count(sat_byte), .rd_ovf(sat_ovf),
        .snap_done(sat_done)
    );

    axis_pkt_stats #(.NUM_CH(3), .DATA_W(32), .PKT_W(4), .BYTE_W(8), .SAT_MODE(0)) u_wrap (
        .clk(clk), .rst(rst), .s_tvalid(t_tvalid), .s_tready(t_tready), .s_tlast(t_tlast),
        .s_tkeep(t_tkeep), .snap_req(t_snap_req), .snap_clr(t_snap_clr), .rd_ch(t_rd_ch),
        .rd_pkt_count(wrap_pkt), .rd_byte_count(wrap_byte), .rd_ovf(wrap_ovf),
        .snap_done(wrap_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic main_beat(input int ch, input logic last, input logic [31:0] keep);
        s_tvalid[ch] = 1'b1;
        s_tready[ch] = 1'b1;
        s_tlast[ch]  = last;
        s_tkeep[ch*32 +: 32] = keep;
        @(negedge clk);
        s_tvalid = '0;
        s_tready = '0;
        s_tlast  = '0;
        s_tkeep  = '0;
    endtask

    task automatic main_snap(input logic clr);
        snap_req = 1'b1;
        snap_clr = clr;
        @(negedge clk);
        snap_req = 1'b0;
        snap_clr = 1'b0;
    endtask

    task automatic main_read(input int ch, input logic [31:0] p, input logic [47:0] b,
                             input logic o, input string tag);
        rd_ch = 2'(ch);
        @(negedge clk);
        chk({tag, "_pkt"},  64'(rd_pkt_count),  64'(p));
        chk({tag, "_byte"}, 64'(rd_byte_count), 64'(b));
        chk({tag, "_ovf"},  64'(rd_ovf),        64'(o));
    endtask

    task automatic t_pkt();
        t_tvalid[0]   = 1'b1;
        t_tready[0]   = 1'b1;
        t_tlast[0]    = 1'b1;
        t_tkeep[3:0]  = 4'h1;
        @(negedge clk);
        t_tvalid = '0;
        t_tready = '0;
        t_tlast  = '0;
        t_tkeep  = '0;
    endtask

    task automatic t_snap(input logic clr);
        t_snap_req = 1'b1;
        t_snap_clr = clr;
        @(negedge clk);
        t_snap_req = 1'b0;
        t_snap_clr = 1'b0;
    endtask

    initial begin
        s_tvalid = '0; s_tready = '0; s_tlast = '0; s_tkeep = '0;
        snap_req = 1'b0; snap_clr = 1'b0; rd_ch = '0;
        t_tvalid = '0; t_tready = '0; t_tlast = '0; t_tkeep = '0;
        t_snap_req = 1'b0; t_snap_clr = 1'b0; t_rd_ch = '0;
        do_reset(3);

        // Reset state
        chk("rst_pkt",  64'(rd_pkt_count),  64'd0);
        chk("rst_byte", 64'(rd_byte_count), 64'd0);
        chk("rst_ovf",  64'(rd_ovf),        64'd0);
        chk("rst_done", 64'(snap_done),     64'd0);

        // ch0: first packet after reset, 3 full beats -> 1 pkt, 96 bytes
        main_beat(0, 1'b0, 32'hFFFF_FFFF);
        main_beat(0, 1'b0, 32'hFFFF_FFFF);
        main_beat(0, 1'b1, 32'hFFFF_FFFF);
        snap_req = 1'b1;
        snap_clr = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        snap_clr = 1'b0;
        chk("snap_done_hi", 64'(snap_done), 64'd1);
        @(negedge clk);
        chk("snap_done_lo", 64'(snap_done), 64'd0);
        main_read(0, 1, 96, 1'b0, "ch0_first");

        // ch1: five 1-beat packets of 4 bytes; lone snap_clr must be ignored
        for (int i = 0; i < 5; i++) main_beat(1, 1'b1, 32'h0000_000F);
        snap_clr = 1'b1;
        @(negedge clk);
        snap_clr = 1'b0;
        main_snap(1'b0);
        main_read(1, 5, 20, 1'b0, "ch1_single");
        main_read(0, 0, 0, 1'b0, "ch0_cleared");
        main_read(2, 0, 0, 1'b0, "ch2_idle");
        main_read(3, 0, 0, 1'b0, "ch3_idle");

        // ch2 beat in the same cycle as a clearing snapshot
        s_tvalid[2] = 1'b1;
        s_tready[2] = 1'b1;
        s_tlast[2]  = 1'b1;
        s_tkeep[64 +: 32] = 32'h0000_00FF;
        snap_req = 1'b1;
        snap_clr = 1'b1;
        @(negedge clk);
        s_tvalid = '0; s_tready = '0; s_tlast = '0; s_tkeep = '0;
        snap_req = 1'b0;
        snap_clr = 1'b0;
        main_read(2, 0, 0, 1'b0, "ch2_excl");
        main_read(1, 5, 20, 1'b0, "ch1_preclr");
        main_snap(1'b0);
        main_read(2, 1, 8, 1'b0, "ch2_kept");
        main_read(1, 0, 0, 1'b0, "ch1_postclr");

        // Back-to-back snapshots on ch0 (live 0 before this)
        rd_ch = 2'd0;
        main_beat(0, 1'b1, 32'h0000_0003);
        s_tvalid[0] = 1'b1;
        s_tready[0] = 1'b1;
        s_tlast[0]  = 1'b1;
        s_tkeep[31:0] = 32'h0000_000F;
        snap_req = 1'b1;
        @(negedge clk);
        s_tvalid = '0; s_tready = '0; s_tlast = '0; s_tkeep = '0;
        @(negedge clk);
        snap_req = 1'b0;
        chk("b2b_first_pkt",  64'(rd_pkt_count),  64'd1);
        chk("b2b_first_byte", 64'(rd_byte_count), 64'd2);
        @(negedge clk);
        chk("b2b_second_pkt",  64'(rd_pkt_count),  64'd2);
        chk("b2b_second_byte", 64'(rd_byte_count), 64'd6);

        // ch3: 10 stalled cycles then one accept, then a non-contiguous beat
        s_tvalid[3] = 1'b1;
        s_tready[3] = 1'b0;
        s_tlast[3]  = 1'b0;
        s_tkeep[96 +: 32] = 32'h0000_0003;
        repeat (10) @(negedge clk);
        s_tready[3] = 1'b1;
        @(negedge clk);
        s_tvalid = '0; s_tready = '0; s_tlast = '0; s_tkeep = '0;
        main_beat(3, 1'b0, 32'h0000_0101);
        main_snap(1'b0);
        main_read(3, 1, 4, 1'b0, "ch3_stall");

        // Reset mid-packet: next beat on ch3 starts a packet
        do_reset(2);
        chk("midrst_pkt",  64'(rd_pkt_count),  64'd0);
        chk("midrst_byte", 64'(rd_byte_count), 64'd0);
        main_beat(3, 1'b0, 32'h0000_000F);
        main_snap(1'b0);
        main_read(0, 0, 0, 1'b0, "sw_ch0");
        main_read(3, 1, 4, 1'b0, "sw_ch3");

        // PKT_W=4: 17 packets -> saturate at 15 / wrap to 1, ovf sticky
        for (int i = 0; i < 17; i++) t_pkt();
        t_snap(1'b0);
        t_rd_ch = 2'd0;
        @(negedge clk);
        chk("sat_pkt",   64'(sat_pkt),   64'd15);
        chk("sat_ovf",   64'(sat_ovf),   64'd1);
        chk("sat_byte",  64'(sat_byte),  64'd17);
        chk("wrap_pkt",  64'(wrap_pkt),  64'd1);
        chk("wrap_ovf",  64'(wrap_ovf),  64'd1);
        chk("wrap_byte", 64'(wrap_byte), 64'd17);
        t_rd_ch = 2'd3;
        @(negedge clk);
        chk("oor_pkt",  64'(sat_pkt),  64'd0);
        chk("oor_byte", 64'(sat_byte), 64'd0);
        chk("oor_ovf",  64'(sat_ovf),  64'd0);
        t_rd_ch = 2'd0;
        t_snap(1'b1);
        t_snap(1'b0);
        @(negedge clk);
        chk("sat_clr_ovf",  64'(sat_ovf),  64'd0);
        chk("sat_clr_pkt",  64'(sat_pkt),  64'd0);
        chk("wrap_clr_ovf", 64'(wrap_ovf), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
